// File: rtl/inst_packer.sv
// inst_packer: packs RV32I fields and an immediate into instruction words, buffers two and writes them to imem.
// Immediate range checking is enabled by defining INST_PACKER_RANGE_CHK_EN.
module inst_packer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_sel,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic        wr_en,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        err,
    output logic [7:0]  err_count
);
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH_WORDS - 1));
    logic [31:0] enc;
    logic [31:0] mem [2];
    logic [1:0]  count;
    logic        legal, accept, push, pop, rd_ptr, wr_ptr;
    always_comb begin
        enc = 32'h0;
        case (imm_sel)
            3'b000:  enc = {imm[11:0], rs1, funct3, rd, opcode};
            3'b001:  enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'b010:  enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            3'b011:  enc = {imm[31:12], rd, opcode};
            3'b110:  enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            3'b101:  enc = {funct7, rs2, rs1, funct3, rd, opcode};
            default: enc = 32'h0;
        endcase
    end
`ifdef INST_PACKER_RANGE_CHK_EN
    // Each format must reproduce the full 32-bit immediate after sign extension
    always_comb begin
        legal = 1'b0;
        case (imm_sel)
            3'b000, 3'b001: legal = (&imm[31:11]) | ~(|imm[31:11]);
            3'b010:         legal = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
            3'b011:         legal = ~(|imm[11:0]);
            3'b110:         legal = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
            3'b101:         legal = 1'b1;
            default:        legal = 1'b0;
        endcase
    end
`else
    assign legal = imm_sel != 3'b100 && imm_sel != 3'b111;
`endif
    assign in_ready = ~count[1];
    assign wr_en    = |count;
    assign wr_data  = wr_en ? mem[rd_ptr] : 32'h0;
    assign accept   = in_valid & in_ready & ~clear;
    assign push     = accept & legal;
    assign pop      = wr_en & wr_ready & ~clear;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            wr_addr   <= BASE_ADDR;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (clear) begin
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            wr_addr   <= BASE_ADDR;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                wr_addr <= wr_addr == LAST_ADDR ? BASE_ADDR : wr_addr + 32'd4;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            err   <= accept & ~legal;
            if (accept & ~legal & ~(&err_count)) err_count <= err_count + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc;
    end
endmodule

// File: doc/inst_packer.md
Name: inst_packer

Overview:
- Inverse of the immediate generator: packs decoded instruction fields plus a 32-bit immediate into a RISC-V RV32I instruction word.
- Buffers encoded words in a 2-entry FIFO and writes them to instruction memory at an auto-incrementing address.
- Used as the program loader / self-test stimulus source in front of the instruction memory.
- Range-checks immediates and drops unencodable requests with an error report.

Parameters:
- BASE_ADDR, 32'h0000_0000, first instruction-memory byte address written after reset or clear.
- DEPTH_WORDS, 256, number of words in the target region; address wraps after the last word (power of 2, >=2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush: empties FIFO, reloads address to BASE_ADDR, zeroes err_count.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- imm_sel  input  3  000 I, 001 S, 010 B, 011 U, 110 J, 101 R (no immediate); 100/111 invalid.
- imm  input  32  full-width immediate value.
- opcode  input  7  opcode field.
- rd, rs1, rs2  input  5 each  register fields.
- funct3  input  3.
- funct7  input  7  used only for R.
- wr_en  output  1  memory write request.
- wr_ready  input  1  memory accepts the write this cycle.
- wr_addr  output  32  byte address, word aligned.
- wr_data  output  32  encoded instruction.
- err  output  1  one-cycle pulse on a dropped request.
- err_count  output  8  saturating count of dropped requests.

Behaviour:
- Reset: in_ready=1, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, err=0, err_count=0, FIFO empty.
- Encoding:
  - I: {imm[11:0],rs1,funct3,rd,opcode}.
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
  - U: {imm[31:12],rd,opcode}.
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
  - R: {funct7,rs2,rs1,funct3,rd,opcode}.
- Legality:
  - I/S: imm[31:11] all equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - U: imm[11:0]=0.
  - J: imm[0]=0 and imm[31:20] all equal.
  - R: always legal.
  - imm_sel 100/111: always illegal.
- Accept in cycle N:
  - Legal request: encoded word pushed at edge ending N.
  - Illegal request: nothing pushed; err=1 in cycle N+1; err_count increments, saturating at 255.
- in_ready = (fifo_count < 2). No same-cycle pass-through when full.
- wr_en = FIFO non-empty. wr_data is the FIFO head, stable while wr_en && !wr_ready.
- First write visible in cycle N+1 for an accept in cycle N into an empty FIFO.
- On wr_en && wr_ready: pop, and wr_addr += 4.
  - At BASE_ADDR + 4*(DEPTH_WORDS-1), wr_addr wraps to BASE_ADDR.
- Simultaneous push and pop with count=1: count stays 1, order preserved.
- clear has priority over push/pop in the same cycle. An accepted request in a clear cycle is discarded.
- Reset mid-write: outputs return to reset values immediately. An in-flight word is lost.

Optional Feature:
- INST_PACKER_RANGE_CHK_EN
- Defined: legality checks above; illegal requests dropped; err and err_count active.
- Undefined: imm_sel 000/001/010/011/110/101 always legal, with immediate bits truncated silently per the encoding. Only imm_sel 100/111 are dropped and counted.

Test Plan:
- Reset, then I-type (imm=5, rd=1, rs1=0, funct3=0, opcode=0x13), wr_ready=1 -> cycle N+1: wr_en=1, wr_addr=0x0, wr_data=0x00500093.
- S (imm=8, rs1=1, rs2=2, funct3=2, opcode=0x23), then B (imm=0xFFFFFFFC, rs1=1, rs2=2, funct3=0, opcode=0x63), back-to-back -> writes 0x0020A423 @0x0, 0xFE208EE3 @0x4.
- U (imm=0x12345000, rd=5, opcode=0x37) and J (imm=8, rd=1, opcode=0x6F) with wr_ready=0 for 5 cycles -> in_ready=0 after 2 accepts; wr_data held at 0x123452B7; after release, 0x008000EF follows at next address.
- With INST_PACKER_RANGE_CHK_EN: I imm=2048, then B imm=3 -> no writes; err pulses twice; err_count=2; wr_addr unchanged. Without the macro: I writes imm[11:0]=0x800 into the word.
- DEPTH_WORDS=4, five legal R-type requests -> addresses 0x0, 0x4, 0x8, 0xC, 0x0.
- Assert clear while FIFO holds 2 words -> next cycle wr_en=0, wr_addr=BASE_ADDR, err_count=0. Assert rst during a stalled write -> wr_en drops without waiting for a clock edge.
